// File: rtl/range_gate_sampler.sv
// Range-gate capture: skips a programmable number of ADC samples after a trigger, then
// averages groups of 2^AVG_LOG2 samples into tagged 16-bit FIFO words. Option: RGS_OFFSET_BINARY_EN.
module range_gate_sampler #(
   parameter int SAMPLE_W = 14,
   parameter int AVG_LOG2 = 2,
   parameter int DEPTH    = 120,
   parameter int DELAY_W  = 8
) (
   input  logic                mainclk,
   input  logic                rstb,
   input  logic                trigger,
   input  logic [DELAY_W-1:0]  gate_delay,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
   input  logic                fifo_full,
   output logic                fifo_wr_en,
   output logic [15:0]         fifo_data,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [1:0]          state_dbg
);

   localparam int         ACC_W    = SAMPLE_W + AVG_LOG2;
   localparam logic [3:0] GRP_LAST = 4'((1 << AVG_LOG2) - 1);
   localparam logic [7:0] DEPTH_C  = 8'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACCUM, S_DONE} state_t;

   state_t               state_q, state_d;
   logic                 trig_q, trig_prev_q;
   logic [DELAY_W-1:0]   dly_cnt_q, dly_cnt_d;
   logic [3:0]           grp_cnt_q, grp_cnt_d;
   logic [7:0]           word_cnt_q, word_cnt_d;
   logic [1:0]           seq_q, seq_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic                 wr_en_q, wr_en_d;
   logic [15:0]          data_q, data_d;
   logic                 ovf_q, ovf_d;

   logic                 trig_edge;
   logic [ACC_W-1:0]     sample_ext;
   logic [ACC_W-1:0]     sum;
   logic [SAMPLE_W-1:0]  avg;
`ifdef RGS_OFFSET_BINARY_EN
   logic signed [SAMPLE_W-1:0] sample_s;
`endif

   // Trigger passes through an input register; the edge is taken between that register and its previous value.
   assign trig_edge = trig_q & ~trig_prev_q;

   always_comb begin
`ifdef RGS_OFFSET_BINARY_EN
      sample_s   = {~adc_data[SAMPLE_W-1], adc_data[SAMPLE_W-2:0]};
      sample_ext = ACC_W'(sample_s);
      sum        = acc_q + sample_ext;
      avg        = SAMPLE_W'($signed(sum) >>> AVG_LOG2);
`else
      sample_ext = ACC_W'(adc_data);
      sum        = acc_q + sample_ext;
      avg        = SAMPLE_W'(sum >> AVG_LOG2);
`endif
   end

   // fifo_wr_en is a push-only strobe: fifo_full is sampled on the same edge that forms the word;
   // a full FIFO drops the word and sets the sticky overflow flag, the capture never stalls.
   always_comb begin
      state_d    = state_q;
      dly_cnt_d  = dly_cnt_q;
      grp_cnt_d  = grp_cnt_q;
      word_cnt_d = word_cnt_q;
      seq_d      = seq_q;
      acc_d      = acc_q;
      wr_en_d    = 1'b0;
      data_d     = data_q;
      ovf_d      = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (trig_edge) begin
               state_d    = S_DELAY;
               dly_cnt_d  = gate_delay;
               ovf_d      = 1'b0;
               word_cnt_d = 8'd0;
               seq_d      = 2'd0;
               acc_d      = '0;
               grp_cnt_d  = 4'd0;
            end
         end
         S_DELAY: begin
            if (dly_cnt_q == '0) begin
               state_d = S_ACCUM;
            end else if (adc_valid) begin
               dly_cnt_d = dly_cnt_q - DELAY_W'(1);
               if (dly_cnt_q == DELAY_W'(1)) state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (word_cnt_q == DEPTH_C) begin
               state_d = S_DONE;
            end else if (adc_valid) begin
               if (grp_cnt_q == GRP_LAST) begin
                  data_d     = {seq_q, avg[13:0]};
                  wr_en_d    = ~fifo_full;
                  ovf_d      = ovf_q | fifo_full;
                  acc_d      = '0;
                  grp_cnt_d  = 4'd0;
                  seq_d      = seq_q + 2'd1;
                  word_cnt_d = word_cnt_q + 8'd1;
               end else begin
                  acc_d     = sum;
                  grp_cnt_d = grp_cnt_q + 4'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge mainclk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= S_IDLE;
         trig_q      <= 1'b0;
         trig_prev_q <= 1'b0;
         dly_cnt_q   <= '0;
         grp_cnt_q   <= 4'd0;
         word_cnt_q  <= 8'd0;
         seq_q       <= 2'd0;
         acc_q       <= '0;
         wr_en_q     <= 1'b0;
         data_q      <= 16'd0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         trig_q      <= trigger;
         trig_prev_q <= trig_q;
         dly_cnt_q   <= dly_cnt_d;
         grp_cnt_q   <= grp_cnt_d;
         word_cnt_q  <= word_cnt_d;
         seq_q       <= seq_d;
         acc_q       <= acc_d;
         wr_en_q     <= wr_en_d;
         data_q      <= data_d;
         ovf_q       <= ovf_d;
      end
   end

   assign fifo_wr_en = wr_en_q;
   assign fifo_data  = data_q;
   assign overflow   = ovf_q;
   assign busy       = (state_q == S_DELAY) || (state_q == S_ACCUM);
   assign done       = (state_q == S_DONE);
   assign state_dbg  = state_q;

endmodule
